// File: rtl/lsu_pkg.sv
// LSU shared definitions: FSM state encoding and
// funct3 access-size encodings.
package lsu_pkg;

    localparam int FUNCT3_W = 3;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUS  = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// LSU lane steering: byte enables, store replication,
// load extraction/extension and legality check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                we_i,
    input  logic [FUNCT3_W-1:0] funct3_i,
    input  logic [1:0]          off_i,
    input  logic [31:0]         wdata_i,
    input  logic [31:0]         rdata_i,
    output logic [3:0]          be_o,
    output logic [31:0]         wdata_o,
    output logic [31:0]         rdata_o,
    output logic                illegal_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    // Decode size, alignment and data steering from funct3
    always_comb begin
        be_o      = 4'b0000;
        wdata_o   = wdata_i;
        rdata_o   = '0;
        illegal_o = 1'b0;
        unique case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                be_o    = 4'b0001 << off_i;
                rdata_o = {24'd0, shifted[7:0]};
            end
            F3_H: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = {{16{shifted[15]}}, shifted[15:0]};
                illegal_o = off_i[0];
            end
            F3_HU: begin
                be_o      = off_i[1] ? 4'b1100 : 4'b0011;
                rdata_o   = {16'd0, shifted[15:0]};
                illegal_o = off_i[0];
            end
            F3_W: begin
                be_o      = 4'b1111;
                rdata_o   = rdata_i;
                illegal_o = (off_i != 2'b00);
            end
            default: illegal_o = 1'b1;
        endcase
        if (we_i && funct3_i[2]) begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding request, IDLE/BUS/RESP
// FSM bridging the core to a valid/ready memory port.
module lsu
    import lsu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [D_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               busy,
    output logic               rsp_valid,
    output logic [D_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    state_t state_q, state_d;

    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [D_WIDTH-1:0]  rsp_rdata_q;
    logic                mem_valid_q;
    logic                mem_we_q;
    logic [D_WIDTH-1:0]  mem_addr_q;
    logic [3:0]          mem_be_q;
    logic [D_WIDTH-1:0]  mem_wdata_q;
    logic [FUNCT3_W-1:0] f3_q;
    logic [1:0]          off_q;

    logic                idle;
    logic                al_we;
    logic [FUNCT3_W-1:0] al_f3;
    logic [1:0]          al_off;
    logic [3:0]          al_be;
    logic [31:0]         al_wdata;
    logic [31:0]         al_rdata;
    logic                al_illegal;

    assign idle   = (state_q == ST_IDLE);
    // In IDLE the aligner sees the incoming request, otherwise
    // the captured one so load data can be extracted at handshake.
    assign al_we  = idle ? req_we : mem_we_q;
    assign al_f3  = idle ? req_funct3 : f3_q;
    assign al_off = idle ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .we_i      (al_we),
        .funct3_i  (al_f3),
        .off_i     (al_off),
        .wdata_i   (req_wdata),
        .rdata_i   (mem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata),
        .illegal_o (al_illegal)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = al_illegal ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            f3_q        <= '0;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid && al_illegal) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else if (req_valid) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= req_we;
                        mem_addr_q  <= {req_addr[D_WIDTH-1:2], 2'b00};
                        mem_be_q    <= al_be;
                        mem_wdata_q <= al_wdata;
                        f3_q        <= req_funct3;
                        off_q       <= req_addr[1:0];
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= mem_we_q ? '0 : al_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = !idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the LSU.
// Inputs driven 1 time unit after posedge; outputs sampled there.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk;
    int n_pass;

    lsu #(.D_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one accepting edge
    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tick();
        req_valid  = 1'b0;
    endtask

    // Legal op with mem_ready=1: check bus beat then response
    task automatic do_op(input string tag, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] ebe, input logic [31:0] eaddr,
                         input logic [31:0] ewd, input logic [31:0] erd);
        mem_ready = 1'b1;
        mem_rdata = rd;
        send(we, f3, a, wd);
        chk({tag, ".mvalid"}, {31'd0, mem_valid}, 32'd1);
        chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, ebe});
        chk({tag, ".addr"}, mem_addr, eaddr);
        chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, we});
        if (we) chk({tag, ".wdata"}, mem_wdata, ewd);
        chk({tag, ".rsp_early"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        chk({tag, ".rvalid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".rerr"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, ".rdata"}, rsp_rdata, erd);
        chk({tag, ".mv_drop"}, {31'd0, mem_valid}, 32'd0);
        tick();
        chk({tag, ".rv_end"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Illegal op: error response one cycle later, no bus activity
    task automatic do_err(input string tag, input logic we,
                          input logic [2:0] f3, input logic [31:0] a);
        mem_ready = 1'b1;
        send(we, f3, a, 32'hFFFF_FFFF);
        chk({tag, ".mvalid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, ".rvalid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, ".rerr"}, {31'd0, rsp_err}, 32'd1);
        chk({tag, ".rdata"}, rsp_rdata, 32'd0);
        tick();
        chk({tag, ".rv_end"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, ".mv_end"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        repeat (3) tick();
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rerr", {31'd0, rsp_err}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.mvalid", {31'd0, mem_valid}, 32'd0);
        chk("rst.mwe", {31'd0, mem_we}, 32'd0);
        chk("rst.mbe", {28'd0, mem_be}, 32'd0);
        chk("rst.maddr", mem_addr, 32'd0);
        chk("rst.mwdata", mem_wdata, 32'd0);

        // LW pending while in reset, accepted on first edge after release
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h100;
        mem_ready  = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("lw.mvalid", {31'd0, mem_valid}, 32'd1);
        chk("lw.be", {28'd0, mem_be}, 32'h0000_000F);
        chk("lw.addr", mem_addr, 32'h100);
        chk("lw.we", {31'd0, mem_we}, 32'd0);
        chk("lw.busy", {31'd0, busy}, 32'd1);
        tick();
        chk("lw.rvalid", {31'd0, rsp_valid}, 32'd1);
        chk("lw.rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("lw.rerr", {31'd0, rsp_err}, 32'd0);
        tick();
        chk("lw.rv_end", {31'd0, rsp_valid}, 32'd0);
        chk("lw.idle", {31'd0, busy}, 32'd0);

        do_op("lb", 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000,
              4'b1000, 32'h100, 32'd0, 32'hFFFF_FF80);
        do_op("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_0000,
              4'b1000, 32'h100, 32'd0, 32'h0000_0080);
        do_op("lb1", 1'b0, 3'b000, 32'h101, 32'd0, 32'h0000_7F00,
              4'b0010, 32'h100, 32'd0, 32'h0000_007F);
        do_op("lh", 1'b0, 3'b001, 32'h102, 32'd0, 32'h8001_1234,
              4'b1100, 32'h100, 32'd0, 32'hFFFF_8001);
        do_op("lhu", 1'b0, 3'b101, 32'h102, 32'd0, 32'h8001_1234,
              4'b1100, 32'h100, 32'd0, 32'h0000_8001);
        do_op("lh0", 1'b0, 3'b001, 32'h100, 32'd0, 32'h8001_1234,
              4'b0011, 32'h100, 32'd0, 32'h0000_1234);
        do_op("sh", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF,
              4'b1100, 32'h200, 32'hABCD_ABCD, 32'd0);
        do_op("sb", 1'b1, 3'b000, 32'h201, 32'h0000_115A, 32'hFFFF_FFFF,
              4'b0010, 32'h200, 32'h5A5A_5A5A, 32'd0);
        do_op("sw", 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'hFFFF_FFFF,
              4'b1111, 32'h300, 32'hCAFE_F00D, 32'd0);

        do_err("e_lw101", 1'b0, 3'b010, 32'h101);
        do_err("e_lh103", 1'b0, 3'b001, 32'h103);
        do_err("e_sw102", 1'b1, 3'b010, 32'h102);
        do_err("e_sbu", 1'b1, 3'b100, 32'h200);
        do_err("e_f3_011", 1'b0, 3'b011, 32'h200);
        do_err("e_f3_111", 1'b0, 3'b111, 32'h200);

        // Stall: mem_ready low for 5 cycles, interloper request ignored
        mem_ready = 1'b0;
        mem_rdata = 32'h1122_3344;
        send(1'b0, 3'b010, 32'h400, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_funct3 = 3'b010;
                req_addr   = 32'h500;
                req_wdata  = 32'h5555_5555;
            end else begin
                req_valid = 1'b0;
            end
            chk("stall.mvalid", {31'd0, mem_valid}, 32'd1);
            chk("stall.addr", mem_addr, 32'h400);
            chk("stall.be", {28'd0, mem_be}, 32'h0000_000F);
            chk("stall.we", {31'd0, mem_we}, 32'd0);
            chk("stall.busy", {31'd0, busy}, 32'd1);
            chk("stall.rvalid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        req_valid = 1'b0;
        mem_ready = 1'b1;
        chk("stall.mv_last", {31'd0, mem_valid}, 32'd1);
        tick();
        chk("stall.rvalid1", {31'd0, rsp_valid}, 32'd1);
        chk("stall.rdata", rsp_rdata, 32'h1122_3344);
        tick();
        chk("stall.rv_end", {31'd0, rsp_valid}, 32'd0);
        chk("stall.idle", {31'd0, busy}, 32'd0);
        tick();
        chk("stall.no_2nd_mv", {31'd0, mem_valid}, 32'd0);
        chk("stall.no_2nd_rv", {31'd0, rsp_valid}, 32'd0);

        // Reset in the middle of a bus transaction
        mem_ready = 1'b0;
        send(1'b0, 3'b010, 32'h600, 32'd0);
        chk("rbus.mvalid", {31'd0, mem_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rbus.mv_async", {31'd0, mem_valid}, 32'd0);
        chk("rbus.busy_async", {31'd0, busy}, 32'd0);
        chk("rbus.addr_async", mem_addr, 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rbus.no_rv", {31'd0, rsp_valid}, 32'd0);
            chk("rbus.no_mv", {31'd0, mem_valid}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
